// File: rtl/count_step_ctrl.sv
// Job sequencer for the 4-bit step counter: runs count from 0 to a latched target using
// +1 or +2 increments, then pulses done for one cycle.
module count_step_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] target,
    input  logic             mode,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             ctrl_step,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] steps
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] steps_q, steps_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             mode_q, mode_d;

    logic [WIDTH-1:0] remaining;
    logic             accept;
    logic             incr;

    // target_q >= count_q always holds, so this subtraction never wraps.
    assign remaining = target_q - count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start && !abort) state_d = StRun;
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (remaining == '0) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (state_q == StRun);
        done      = (state_q == StDone);
        accept    = (state_q == StIdle) && start && !abort;
        incr      = busy && !abort && (remaining != '0);
        ctrl_step = incr && !rst && mode_q && (remaining > WIDTH'(1));
    end

    always_comb begin
        count_d  = count_q;
        steps_d  = steps_q;
        target_d = target_q;
        mode_d   = mode_q;
        if (accept) begin
            count_d  = '0;
            steps_d  = '0;
            target_d = target;
            mode_d   = mode;
        end else if (incr) begin
            count_d = count_q + (ctrl_step ? WIDTH'(2) : WIDTH'(1));
            steps_d = steps_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            steps_q  <= '0;
            target_q <= '0;
            mode_q   <= 1'b0;
        end else begin
            count_q  <= count_d;
            steps_q  <= steps_d;
            target_q <= target_d;
            mode_q   <= mode_d;
        end
    end

    assign count = count_q;
    assign steps = steps_q;

endmodule

// File: tb/tb_count_step_ctrl.sv
// Bench for count_step_ctrl: directed scenarios plus random traffic, all checked every
// cycle against a job-level model that predicts count from a closed-form schedule.
module tb_count_step_ctrl;

    logic       clk = 1'b0;
    logic       r_rst = 1'b0;
    logic       r_start = 1'b0;
    logic [3:0] r_target = '0;
    logic       r_mode = 1'b0;
    logic       r_abort = 1'b0;
    logic [3:0] count;
    logic       ctrl_step;
    logic       busy;
    logic       done;
    logic [3:0] steps;

    int total = 0;
    int bad   = 0;

    // Model: phase 0 idle, 1 running (k cycles since acceptance), 2 done pulse.
    int m_phase = 0;
    int m_k = 0, m_n = 0, m_t = 0, m_mode = 0;
    int m_count = 0, m_steps = 0;
    bit m_valid = 1'b0;

    always #5 clk = ~clk;

    count_step_ctrl #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (r_rst),
        .start    (r_start),
        .target   (r_target),
        .mode     (r_mode),
        .abort    (r_abort),
        .count    (count),
        .ctrl_step(ctrl_step),
        .busy     (busy),
        .done     (done),
        .steps    (steps)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Count expected after k increments of the current job.
    function automatic int sched(input int k);
        if (m_mode != 0) return (2 * k < m_t) ? 2 * k : m_t;
        return k;
    endfunction

    task automatic model_compare();
        int e_count, e_steps, e_ctrl;
        if (!m_valid) return;
        e_count = (m_phase == 1) ? sched(m_k) : m_count;
        e_steps = (m_phase == 1) ? m_k : m_steps;
        e_ctrl  = (m_phase == 1 && !r_rst && !r_abort && m_k < m_n &&
                   sched(m_k + 1) - sched(m_k) == 2) ? 1 : 0;
        check("count", int'(count), e_count);
        check("steps", int'(steps), e_steps);
        check("busy", int'(busy), (m_phase == 1) ? 1 : 0);
        check("done", int'(done), (m_phase == 2) ? 1 : 0);
        check("ctrl_step", int'(ctrl_step), e_ctrl);
    endtask

    task automatic model_step();
        if (r_rst) begin
            m_phase = 0; m_count = 0; m_steps = 0; m_t = 0; m_mode = 0; m_k = 0;
            m_valid = 1'b1;
            return;
        end
        case (m_phase)
            0: if (r_start && !r_abort) begin
                m_phase = 1; m_k = 0; m_t = int'(r_target); m_mode = int'(r_mode);
                m_n = m_mode ? (m_t + 1) / 2 : m_t;
                m_count = 0; m_steps = 0;
            end
            1: begin
                if (r_abort) begin
                    m_phase = 0; m_count = sched(m_k); m_steps = m_k;
                end else if (m_k == m_n) begin
                    m_phase = 2; m_count = m_t; m_steps = m_n;
                end else begin
                    m_k++;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    // One clock: drive at negedge, compare mid-low-phase, update model at posedge.
    task automatic cyc(input bit rs, input bit st, input int tg, input bit md, input bit ab);
        @(negedge clk);
        r_rst = rs; r_start = st; r_target = 4'(tg); r_mode = md; r_abort = ab;
        #1 model_compare();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset held two cycles with start asserted.
        cyc(1'b1, 1'b1, 5, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 5, 1'b1, 1'b0);
        check("rst_count", int'(count), 0);
        check("rst_steps", int'(steps), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        idle(1);
        check("rst_stays_idle", int'(busy), 0);

        // Fast job, target 7: 2,4,6,7 then done after E5.
        cyc(1'b0, 1'b1, 7, 1'b1, 1'b0);
        check("fast_busy_e0", int'(busy), 1);
        idle(1);
        check("fast_e1_count", int'(count), 2);
        idle(4);
        check("fast_done", int'(done), 1);
        check("fast_count", int'(count), 7);
        check("fast_steps", int'(steps), 4);
        idle(1);
        check("fast_done_low", int'(done), 0);

        // Unit job, target 15.
        cyc(1'b0, 1'b1, 15, 1'b0, 1'b0);
        idle(16);
        check("unit_done", int'(done), 1);
        check("unit_count", int'(count), 15);
        check("unit_steps", int'(steps), 15);
        idle(1);

        // Zero target.
        cyc(1'b0, 1'b1, 0, 1'b1, 1'b0);
        idle(1);
        check("zero_done", int'(done), 1);
        check("zero_count", int'(count), 0);
        idle(1);

        // Abort at E4 then restart with target 2.
        cyc(1'b0, 1'b1, 9, 1'b0, 1'b0);
        idle(3);
        cyc(1'b0, 1'b0, 0, 1'b0, 1'b1);
        check("abort_busy", int'(busy), 0);
        check("abort_count", int'(count), 3);
        check("abort_steps", int'(steps), 3);
        check("abort_done", int'(done), 0);
        cyc(1'b0, 1'b1, 2, 1'b0, 1'b0);
        check("restart_count0", int'(count), 0);
        idle(3);
        check("restart_done", int'(done), 1);
        check("restart_count", int'(count), 2);
        idle(1);

        // start during RUN is ignored, then reset mid-job.
        cyc(1'b0, 1'b1, 3, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 5, 1'b1, 1'b0);
        check("coll_done", int'(done), 1);
        check("coll_count", int'(count), 3);
        idle(1);
        cyc(1'b0, 1'b1, 9, 1'b1, 1'b0);
        idle(1);
        cyc(1'b1, 1'b0, 0, 1'b0, 1'b0);
        check("midrst_count", int'(count), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_steps", int'(steps), 0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 63) == 0),
                ($urandom_range(0, 2) == 0),
                int'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 15) == 0));
        end
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/count_step_ctrl.md
# count_step_ctrl

Sequencer for the team's 4-bit step counter (selectable +1 / +2 increment). Given a target value and a mode, it runs the counter from zero to the target, choosing the increment each cycle. When the count reaches the target it pulses `done`. It sits between the control logic issuing count jobs and the step-counter datapath, which is embedded here so that count, step selection and bookkeeping stay in one clock domain.

## Interface
- `WIDTH`, default 4: width of count, target and step tally.

- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: reset, synchronous, active-high; highest priority.
- `start` in 1: job request; sampled only in IDLE.
- `target` in WIDTH: final count value; latched when `start` is accepted.
- `mode` in 1: latched with `start`. 1 = fast (use +2 where possible); 0 = unit steps only.
- `abort` in 1: cancels a running job.
- `count` out WIDTH: current counter value (registered).
- `ctrl_step` out 1: step select for the next edge (1 = +2, 0 = +1). Combinational; 0 outside RUN.
- `busy` out 1: high while state is RUN.
- `done` out 1: one-cycle completion pulse (registered, high in DONE).
- `steps` out WIDTH: number of increments applied in the current/last job (registered).

## Operation
- States: IDLE, RUN, DONE. Reset state: IDLE.
- Reset values: `count`=0, `steps`=0, `busy`=0, `done`=0, `ctrl_step`=0, latched target/mode = 0.
- IDLE:
  - `start`=1 and `abort`=0: latch `target` and `mode`; `count`←0; `steps`←0; go to RUN.
  - `abort`=1: stay in IDLE, even if `start`=1.
  - Otherwise `count` and `steps` hold their last job's values.
- RUN, with `remaining` = `target_q` − `count` (unsigned, WIDTH bits):
  - `abort`=1: go to IDLE; no increment; `count`/`steps` hold; no `done`.
  - `remaining`=0: go to DONE; no increment.
  - `mode_q`=1 and `remaining` ≥ 2: `ctrl_step`=1; `count`←`count`+2; `steps`+1.
  - Otherwise: `ctrl_step`=0; `count`←`count`+1; `steps`+1.
- DONE: `done`=1 for exactly one cycle; `count`/`steps` hold; next state is IDLE unconditionally. `start` is ignored in DONE.
- Arithmetic:
  - `count` never exceeds `target_q`, so no wrap-around is possible.
  - In fast mode, an odd target ends with exactly one +1 step.
  - `steps` ≤ 2^WIDTH−1 (unit mode, target 15), so it never overflows.
- `start` while `busy` is ignored; the latched target and mode do not change mid-job.

## Timing
- `start` accepted at edge E0: `busy` high from E0; first increment at E1.
- `done` high in the cycle after edge E(steps+1), then low after the following edge. `busy` drops at the same edge `done` rises.
- Steps taken:
  - Unit mode: `steps` = `target`.
  - Fast mode: `steps` = ceil(`target`/2).
- Target 0: RUN for one cycle, then DONE; `steps`=0, `count`=0.
- Earliest next `start` acceptance: the edge after DONE (IDLE cycle).
- `rst` mid-job: at the next edge, all outputs take their reset values and the state returns to IDLE; no `done`.
- `abort` and `rst` together: reset behaviour.

## Test plan
- Reset: hold `rst` 2 cycles with `start`=1 → `count`=0, `steps`=0, `busy`=0, `done`=0; state stays IDLE.
- Fast job: `target`=7, `mode`=1, pulse `start` → `count` 2,4,6,7 on E1..E4; `ctrl_step` 1,1,1,0; `done` high one cycle after E5; `steps`=4.
- Unit job: `target`=15, `mode`=0 → 15 unit steps; `count` ends at 15 with no wrap; `steps`=15; `done` after E16.
- Zero target: `target`=0, `mode`=1 → `busy` one cycle; `done` after E1; `count`=0; `steps`=0.
- Abort and restart: `target`=9, `mode`=0, `abort` at E4 (count 3) → IDLE; `count`=3, `steps`=3, no `done`. A new `start` with `target`=2 → `count` 0,1,2 (restarts from 0) and `done`.
- Collisions: `start` with `target`=5 asserted during RUN of a `target`=3 job → ignored; job ends at 3. Then `rst` at E2 of a new job → all outputs zero at the next edge.
